// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a start/busy/done handshake. ADD/SUB/AND/ORR finish in one cycle; MUL/UMULL/SMULL/UDIV iterate.
// Define SEQ_ALU_EARLY_TERM_EN to let multiplies exit as soon as the remaining multiplier bits are zero.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultExtra,
  output logic [3:0]       ALUFlags
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   extra_q, extra_d;
  logic [3:0]         flags_q, flags_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic               mulLast;
  logic [WIDTH:0]     divShift;
  logic               divGe;
  logic [2*WIDTH-1:0] divNext;
  logic [2*WIDTH-1:0] prodAligned;
  logic [WIDTH:0]     addSum;
  logic [WIDTH:0]     subSum;
  logic [WIDTH-1:0]   finResult;
  logic [WIDTH-1:0]   finExtra;
  logic               finC, finV, finN, finZ, longOp;

  // One shift-add multiply step and one restoring-divide step, both working on acc_q.
  always_comb begin
    mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    mulNext  = {mulSum, acc_q[WIDTH-1:1]};
    divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    divGe    = (divShift >= {1'b0, b_q});
    divNext  = {(divGe ? (divShift[WIDTH-1:0] - b_q) : divShift[WIDTH-1:0]),
                acc_q[WIDTH-2:0], divGe};
`ifdef SEQ_ALU_EARLY_TERM_EN
    mulLast = (cnt_q == '0) || (b_q[WIDTH-1:1] == '0);
    // An early exit leaves cnt_q shifts outstanding; a negated product needs sign fill.
    if (neg_q) prodAligned = $unsigned($signed(acc_q) >>> cnt_q);
    else       prodAligned = acc_q >> cnt_q;
`else
    mulLast     = (cnt_q == '0);
    prodAligned = acc_q;
`endif
  end

  always_comb begin
    addSum    = {1'b0, a_q} + {1'b0, b_q};
    subSum    = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
    finResult = '0;
    finExtra  = '0;
    finC      = 1'b0;
    finV      = 1'b0;
    longOp    = 1'b0;
    case (op_q)
      3'b000: begin
        finResult = addSum[WIDTH-1:0];
        finC      = addSum[WIDTH];
        finV      = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (addSum[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'b001: begin
        finResult = subSum[WIDTH-1:0];
        finC      = subSum[WIDTH];
        finV      = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (subSum[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'b010: finResult = a_q & b_q;
      3'b011: finResult = a_q | b_q;
      3'b100: finResult = prodAligned[WIDTH-1:0];
      3'b101, 3'b110: begin
        {finExtra, finResult} = prodAligned;
        longOp                = 1'b1;
      end
      default: begin
        finResult = acc_q[WIDTH-1:0];
        finExtra  = acc_q[2*WIDTH-1:WIDTH];
        finV      = (b_q == '0);
      end
    endcase
    finN = longOp ? finExtra[WIDTH-1] : finResult[WIDTH-1];
    finZ = longOp ? (prodAligned == '0) : (finResult == '0);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    extra_d  = extra_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = ALUControl;
          a_d   = A;
          b_d   = B;
          neg_d = 1'b0;
          acc_d = '0;
          cnt_d = CNT_INIT;
          case (ALUControl)
            3'b100, 3'b101: state_d = MUL;
            3'b110: begin
              state_d = MUL;
              neg_d   = A[WIDTH-1] ^ B[WIDTH-1];
              a_d     = A[WIDTH-1] ? -A : A;
              b_d     = B[WIDTH-1] ? -B : B;
            end
            3'b111: begin
              state_d = DIV;
              acc_d   = {{WIDTH{1'b0}}, A};
            end
            default: state_d = FIN;
          endcase
        end
      end
      MUL: begin
        b_d = b_q >> 1;
        if (mulLast) begin
          state_d = FIN;
          acc_d   = neg_q ? -mulNext : mulNext;
        end else begin
          acc_d = mulNext;
          cnt_d = cnt_q - CW'(1);
        end
      end
      DIV: begin
        acc_d = divNext;
        if (cnt_q == '0) state_d = FIN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FIN: begin
        state_d  = IDLE;
        done_d   = 1'b1;
        result_d = finResult;
        extra_d  = finExtra;
        flags_d  = {finN, finZ, finC, finV};
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      extra_q  <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      extra_q  <= extra_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign Result      = result_q;
  assign ResultExtra = extra_q;
  assign ALUFlags    = flags_q;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised multi-cycle successor to the single-cycle datapath ALU. Executes add/sub/logic in one cycle, and long multiply (unsigned/signed) and unsigned divide iteratively over WIDTH cycles. Uses a start/busy/done handshake. Sits in the execute stage; the core stalls while busy=1.

Parameters:
WIDTH, 32, operand and Result width; ResultExtra is also WIDTH (high half of a product, or the remainder)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  launch operation; sampled only when busy=0
ALUControl  input  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL (low), 101 UMULL, 110 SMULL, 111 UDIV
A  input  WIDTH  operand A, latched on accepted start
B  input  WIDTH  operand B, latched on accepted start
busy  output  1  operation in flight
done  output  1  one-cycle pulse; Result, ResultExtra and ALUFlags are valid from this cycle on
Result  output  WIDTH  low result, or quotient
ResultExtra  output  WIDTH  high product half, or remainder; 0 for ops 000-100
ALUFlags  output  4  {N,Z,C,V}

Behaviour:
- Reset (reset=0, async): FSM=IDLE, busy=0, done=0, Result=0, ResultExtra=0, ALUFlags=0, internal accumulators cleared. An op in flight is abandoned; no done pulse.
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE, start=1: latch ALUControl, A, B.
  - Ops 000-011 -> FIN.
  - Ops 100-110 -> MUL.
  - Op 111 -> DIV.
  - busy=1 from the next edge.
- MUL: radix-2 shift-add on a 2*WIDTH accumulator. Counter runs WIDTH-1 down to 0. At 0 -> FIN.
- SMULL: operands converted to magnitudes at latch. The product is negated at the MUL->FIN transition if sign(A) XOR sign(B).
- DIV: restoring division, one quotient bit per cycle for WIDTH cycles -> FIN.
- FIN: registers outputs, done=1, busy=0 on the next edge -> IDLE. done is high exactly one cycle.
- Latency, edge sampling start to edge raising done: 1 cycle for 000-011; WIDTH+1 cycles for 100-111.
- Back-to-back: start may be high during the done cycle; it is accepted that cycle, since busy=0.
- start while busy=1: ignored. Inputs A, B and ALUControl may change freely after acceptance.
- Outputs hold their last values until the next done. They are never updated mid-operation.
- Arithmetic:
  - ADD/SUB: WIDTH+1-bit sum; SUB is A + ~B + 1.
  - C = carry out (SUB: C=1 means no borrow).
  - V = signed overflow.
- Flags:
  - AND/ORR: C=0, V=0.
  - Long ops (101, 110): N = MSB of ResultExtra; Z = whole 2*WIDTH product is zero; C=0, V=0.
  - MUL (100): N and Z from Result.
  - UDIV: N, Z from Result; C=0, V=0.
- Divide by zero (B=0): still WIDTH+1 latency. Result = all ones, ResultExtra = A, V=1.

Optional Feature:
SEQ_ALU_EARLY_TERM_EN
- Defined: MUL exits to FIN as soon as the remaining multiplier bits are all zero. The accumulator is shifted into its final alignment in FIN. MUL latency becomes 2 to WIDTH+1 cycles; B=0 takes 2 cycles. DIV is unaffected.
- Undefined: fixed WIDTH+1 latency for all multiplies.

Test Plan:
- Reset: hold reset=0 with start=1 -> busy=0, done=0, all outputs 0. Release reset, ADD 3+4 -> Result=7, ALUFlags=0000, done 1 cycle after start.
- ADD boundary: 0x7FFFFFFF+0x00000001 -> Result=0x80000000, NZCV=1001. SUB 5-5 -> Result=0, NZCV=0110.
- SMULL: A=-45, B=23 -> Result=0xFFFFFBF5, ResultExtra=0xFFFFFFFF, NZCV=1000. done exactly 33 cycles after the start edge (feature off). Also UMULL 0xFFFFFFFF*0xFFFFFFFF -> Result=0x00000001, ResultExtra=0xFFFFFFFE.
- UDIV: 100/7 -> Result=14, ResultExtra=2. Divide by zero, A=9 -> Result=0xFFFFFFFF, ResultExtra=9, V=1.
- Handshake: pulse start again at cycles 5 and 20 of a MUL -> ignored, outputs unchanged until done. start asserted in the done cycle -> the new op is accepted with no gap.
- Mid-op reset: drop reset at cycle 10 of a DIV -> immediate busy=0, outputs 0, no done. Next ORR 0xF0|0x0F -> 0xFF. Early-term build: MUL 123*2 -> 246, done 3 cycles after start.
